// File: rtl/adder_rr_arbiter.sv
// Two-port round-robin front end for one shared WIDTH-bit adder.
// A registered response (sum plus requester id) is held until the consumer takes it.
module adder_rr_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  output logic             resp_id,
  output logic [WIDTH:0]   resp_sum,
  input  logic             resp_ready,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic             last_grant_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic [WIDTH:0]   sum_s;
  logic             resp_valid_r;
  logic             resp_id_r;
  logic [WIDTH:0]   resp_sum_r;
  logic [CNT_W-1:0] ops_done_r;

  // Grant selection, next-state decode and the adder for the granted port
  always_comb begin
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          // tie goes to whichever port did not win last time
          if (last_grant_r) begin
            grant0_s = 1'b1;
          end else begin
            grant1_s = 1'b1;
          end
        end else if (req0_valid) begin
          grant0_s = 1'b1;
        end else if (req1_valid) begin
          grant1_s = 1'b1;
        end else begin
          grant0_s = 1'b0;
          grant1_s = 1'b0;
        end
        if (grant0_s || grant1_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = IDLE;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase

    if (grant1_s) begin
      sum_s = {1'b0, req1_a} + {1'b0, req1_b};
    end else begin
      sum_s = {1'b0, req0_a} + {1'b0, req0_b};
    end
  end

  // ready is only raised toward a valid requester, so a grant is an acceptance
  assign accept_s   = grant0_s || grant1_s;
  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;

  // State, captured result, fairness pointer and completion counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      resp_valid_r <= 1'b0;
      resp_id_r    <= 1'b0;
      resp_sum_r   <= '0;
      ops_done_r   <= '0;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        resp_valid_r <= 1'b1;
        resp_id_r    <= grant1_s;
        resp_sum_r   <= sum_s;
        last_grant_r <= grant1_s;
      end else if ((state_r == RESP) && resp_ready) begin
        resp_valid_r <= 1'b0;
        ops_done_r   <= ops_done_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        resp_valid_r <= resp_valid_r;
      end
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_id_r;
  assign resp_sum   = resp_sum_r;
  assign ops_done   = ops_done_r;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed bench for adder_rr_arbiter: per-cycle vector table plus hand-written
// sequences for fairness, reset mid-operation and counter wrap.
module tb_adder_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic [3:0] req0_a = 4'h0;
  logic [3:0] req0_b = 4'h0;
  logic       req0_ready;
  logic       req1_valid = 1'b0;
  logic [3:0] req1_a = 4'h0;
  logic [3:0] req1_b = 4'h0;
  logic       req1_ready;
  logic       resp_valid;
  logic       resp_id;
  logic [4:0] resp_sum;
  logic       resp_ready = 1'b0;
  logic [7:0] ops_done;

  int checks = 0;
  int fails  = 0;

  adder_rr_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .resp_ready(resp_ready), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       r0v;
    logic [3:0] r0a;
    logic [3:0] r0b;
    logic       r1v;
    logic [3:0] r1a;
    logic [3:0] r1b;
    logic       rr;
    logic       e0rdy;
    logic       e1rdy;
    logic       erv;
    logic       eid;
    logic [4:0] esum;
    logic [7:0] eops;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                       input logic v1, input logic [3:0] a1, input logic [3:0] b1, input logic rr);
    rst = r; req0_valid = v0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_a = a1; req1_b = b1; resp_ready = rr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // rst, r0v, r0a, r0b, r1v, r1a, r1b, rr | req0_ready, req1_ready, resp_valid, resp_id, resp_sum, ops_done
    vecs[0]  = '{1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 8'd0};
    vecs[1]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'h03, 8'd0};
    vecs[2]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h03, 8'd1};
    vecs[3]  = '{1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'h03, 8'd1};
    vecs[4]  = '{1'b0, 1'b1, 4'h4, 4'h3, 1'b1, 4'h9, 4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 8'd0};
    vecs[5]  = '{1'b0, 1'b1, 4'h4, 4'h3, 1'b1, 4'h9, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5'h07, 8'd0};
    vecs[6]  = '{1'b0, 1'b1, 4'h4, 4'h3, 1'b1, 4'h9, 4'h3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'h07, 8'd1};
    vecs[7]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h0C, 8'd1};
    vecs[8]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h0C, 8'd2};
    vecs[9]  = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'hA, 4'hB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'h0C, 8'd2};
    vecs[10] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h15, 8'd2};
    vecs[11] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h15, 8'd2};
    vecs[12] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'h15, 8'd2};
    vecs[13] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'h15, 8'd2};
    vecs[14] = '{1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'h15, 8'd3};

    do_reset();
    #1;
    chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("reset resp_id", {31'd0, resp_id}, 32'd0);
    chk("reset resp_sum", {27'd0, resp_sum}, 32'd0);
    chk("reset ops_done", {24'd0, ops_done}, 32'd0);

    // Per-cycle table: single op, tie after reset, held response
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].r0v, vecs[i].r0a, vecs[i].r0b,
            vecs[i].r1v, vecs[i].r1a, vecs[i].r1b, vecs[i].rr);
      #1;
      chk($sformatf("vec%0d req0_ready", i), {31'd0, req0_ready}, {31'd0, vecs[i].e0rdy});
      chk($sformatf("vec%0d req1_ready", i), {31'd0, req1_ready}, {31'd0, vecs[i].e1rdy});
      chk($sformatf("vec%0d resp_valid", i), {31'd0, resp_valid}, {31'd0, vecs[i].erv});
      chk($sformatf("vec%0d resp_id", i), {31'd0, resp_id}, {31'd0, vecs[i].eid});
      chk($sformatf("vec%0d resp_sum", i), {27'd0, resp_sum}, {27'd0, vecs[i].esum});
      chk($sformatf("vec%0d ops_done", i), {24'd0, ops_done}, {24'd0, vecs[i].eops});
    end

    // Both ports continuously valid: grants alternate 0,1,0,1,0,1
    do_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 4'h2, 4'h1, 1'b1, 4'h5, 4'h6, 1'b1);
      #1;
      if (k % 2 == 0) begin
        chk($sformatf("fair%0d req0_ready", k), {31'd0, req0_ready}, {31'd0, ((k / 2) % 2 == 0)});
        chk($sformatf("fair%0d req1_ready", k), {31'd0, req1_ready}, {31'd0, ((k / 2) % 2 == 1)});
      end else begin
        chk($sformatf("fair%0d resp_valid", k), {31'd0, resp_valid}, 32'd1);
        chk($sformatf("fair%0d resp_id", k), {31'd0, resp_id}, {31'd0, (((k - 1) / 2) % 2 == 1)});
        chk($sformatf("fair%0d resp_sum", k), {27'd0, resp_sum},
            (((k - 1) / 2) % 2 == 1) ? 32'h0B : 32'h03);
      end
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    #1;
    chk("fair ops_done", {24'd0, ops_done}, 32'd6);

    // Reset while in RESP drops the result and restores port 0 priority
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h5, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0);
    #1;
    chk("rstmid req0_ready", {31'd0, req0_ready}, 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    #1;
    chk("rstmid in resp", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b1, 4'h1, 4'h1, 1'b1, 4'h2, 4'h2, 1'b1);
    #1;
    chk("rstmid resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rstmid ops_done", {24'd0, ops_done}, 32'd0);
    chk("rstmid tie req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("rstmid tie req1_ready", {31'd0, req1_ready}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
    #1;
    chk("rstmid tie resp_id", {31'd0, resp_id}, 32'd0);
    chk("rstmid tie resp_sum", {27'd0, resp_sum}, 32'd2);

    // Max operands and ops_done wrap after 256 completions
    do_reset();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 4'hF, i[3:0], 1'b0, 4'h0, 4'h0, 1'b1);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b1);
      #1;
      if (i == 0 || i == 16 || i == 255) begin
        chk($sformatf("wrap%0d resp_sum", i), {27'd0, resp_sum}, 32'h0F + (i % 16));
        chk($sformatf("wrap%0d ops_done", i), {24'd0, ops_done}, i);
      end
    end
    @(negedge clk);
    #1;
    chk("wrap max sum", {27'd0, resp_sum}, 32'h1E);
    chk("wrap ops_done", {24'd0, ops_done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
